// File: rtl/ddr2_pll_reset_ctrl.sv
// ddr2_pll_reset_ctrl
// Sequences the reset of a DDR2 PLL from its reference clock: pulses the PLL
// reset, waits (with timeout and retry) for lock, requires a run of stable
// lock before releasing the downstream reset, and falls back to waiting for
// lock whenever the PLL loses lock while running. Lock losses and lock
// timeouts are counted in saturating 8-bit counters.
module ddr2_pll_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT   = 1024,
    parameter int unsigned STABLE_CYCLES  = 64
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PLL_LOCKED,
    output logic       PLL_RST,
    output logic       RST_N_OUT,
    output logic [7:0] RELOCK_CNT,
    output logic [7:0] TIMEOUT_CNT
);

    // Last counter value of each timed state; the FSM leaves on this value.
    localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYCLES - 32'd1);
    localparam logic [15:0] LOCK_LAST    = 16'(LOCK_TIMEOUT - 32'd1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // Saturating increment for the event counters: holds at 255, never wraps.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    state_e      state_q;
    state_e      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] term_d;
    logic        sync_meta_q;
    logic        lock_sync_q;
    logic        pll_rst_q;
    logic        pll_rst_d;
    logic        rst_n_out_q;
    logic        rst_n_out_d;
    logic [7:0]  relock_q;
    logic [7:0]  relock_d;
    logic [7:0]  timeout_q;
    logic [7:0]  timeout_d;

    // Two-flop synchronizer bringing the asynchronous lock flag into CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            sync_meta_q <= PLL_LOCKED;
            lock_sync_q <= sync_meta_q;
        end
    end

    // Next-state, event-counter and cycle-counter logic for the reset FSM.
    always_comb begin
        state_d   = state_q;
        relock_d  = relock_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        term_d    = 16'd0;

        case (state_q)
            ST_RESET_PLL: begin
                term_d = PLL_RST_LAST;
                if (cnt_q >= PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_WAIT_LOCK: begin
                term_d = LOCK_LAST;
                // Lock is tested first so a lock arriving on the timeout
                // cycle wins over the retry.
                if (lock_sync_q) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q >= LOCK_LAST) begin
                    state_d   = ST_RESET_PLL;
                    timeout_d = sat_inc8(timeout_q);
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABILIZE: begin
                term_d = STABLE_LAST;
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STABILIZE;
                end
            end
            ST_RUN: begin
                term_d = 16'd0;
                if (!lock_sync_q) begin
                    state_d  = ST_WAIT_LOCK;
                    relock_d = sat_inc8(relock_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                term_d  = 16'd0;
                state_d = ST_RESET_PLL;
            end
        endcase

        // Every transition restarts the count; RUN does not count at all, and
        // the other states stop at their terminal value so the count cannot wrap.
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q;
        end else if (cnt_q < term_d) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from the next state so the registered outputs change on
    // the same edge as the state register.
    always_comb begin
        pll_rst_d   = 1'b0;
        rst_n_out_d = 1'b0;
        if (state_d == ST_RESET_PLL) begin
            pll_rst_d = 1'b1;
        end else begin
            pll_rst_d = 1'b0;
        end
        if (state_d == ST_RUN) begin
            rst_n_out_d = 1'b1;
        end else begin
            rst_n_out_d = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= 16'd0;
            pll_rst_q   <= 1'b1;
            rst_n_out_q <= 1'b0;
            relock_q    <= 8'd0;
            timeout_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_n_out_q <= rst_n_out_d;
            relock_q    <= relock_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PLL_RST     = pll_rst_q;
    assign RST_N_OUT   = rst_n_out_q;
    assign RELOCK_CNT  = relock_q;
    assign TIMEOUT_CNT = timeout_q;

endmodule

// File: tb/tb_ddr2_pll_reset_ctrl.sv
// Directed, table-driven bench for ddr2_pll_reset_ctrl with default parameters.
// Timing convention: "tick" = posedge CLK then #1. After the Nth tick following
// reset release, outputs reflect edge N-1 (edge 0 is the first edge after release).
module tb_ddr2_pll_reset_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PLL_LOCKED = 1'b0;
    logic       PLL_RST;
    logic       RST_N_OUT;
    logic [7:0] RELOCK_CNT;
    logic [7:0] TIMEOUT_CNT;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    ddr2_pll_reset_ctrl dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PLL_LOCKED  (PLL_LOCKED),
        .PLL_RST     (PLL_RST),
        .RST_N_OUT   (RST_N_OUT),
        .RELOCK_CNT  (RELOCK_CNT),
        .TIMEOUT_CNT (TIMEOUT_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] adv;     // ticks to advance after driving lock
        logic        lock;    // PLL_LOCKED value driven before advancing
        logic        e_pll;   // expected PLL_RST
        logic        e_rstn;  // expected RST_N_OUT
        logic [7:0]  e_rel;   // expected RELOCK_CNT
        logic [7:0]  e_to;    // expected TIMEOUT_CNT
    } vec_t;

    vec_t vecs[11];

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic e_pll, input logic e_rstn,
                             input logic [7:0] e_rel, input logic [7:0] e_to);
        check1({name, "_pll_rst"}, PLL_RST, e_pll);
        check1({name, "_rst_n_out"}, RST_N_OUT, e_rstn);
        check8({name, "_relock"}, RELOCK_CNT, e_rel);
        check8({name, "_timeout"}, TIMEOUT_CNT, e_to);
    endtask

    // Hold reset for a few edges, check reset outputs, release with the given lock.
    task automatic do_reset(input string name, input logic lock_after);
        RST_N      = 1'b0;
        PLL_LOCKED = 1'b0;
        tick(3);
        check_all({name, "_in_reset"}, 1'b1, 1'b0, 8'd0, 8'd0);
        RST_N      = 1'b1;
        PLL_LOCKED = lock_after;
    endtask

    initial begin
        int unsigned bad;
        logic [7:0]  exp_rel;

        // Normal bring-up with lock 20 cycles after release, then one lock loss in RUN.
        vecs[0]  = '{16'd1,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0}; // T1   edge0: PLL reset held
        vecs[1]  = '{16'd6,  1'b0, 1'b1, 1'b0, 8'd0, 8'd0}; // T7   edge6: still 8th cycle pending
        vecs[2]  = '{16'd1,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0}; // T8   edge7: PLL reset drops
        vecs[3]  = '{16'd12, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0}; // T20  waiting for lock
        vecs[4]  = '{16'd66, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}; // T86  STABILIZE from edge22, not done
        vecs[5]  = '{16'd1,  1'b1, 1'b0, 1'b1, 8'd0, 8'd0}; // T87  edge86: RUN
        vecs[6]  = '{16'd20, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0}; // T107 steady RUN
        vecs[7]  = '{16'd2,  1'b0, 1'b0, 1'b1, 8'd0, 8'd0}; // T109 loss still in synchronizer
        vecs[8]  = '{16'd1,  1'b0, 1'b0, 1'b0, 8'd1, 8'd0}; // T110 3rd edge: RST_N_OUT falls
        vecs[9]  = '{16'd66, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0}; // T176 re-stabilizing
        vecs[10] = '{16'd1,  1'b1, 1'b0, 1'b1, 8'd1, 8'd0}; // T177 edge176: RUN again

        do_reset("tbl", 1'b0);
        for (int i = 0; i < 11; i++) begin
            PLL_LOCKED = vecs[i].lock;
            tick(int'(vecs[i].adv));
            check_all($sformatf("vec%0d", i), vecs[i].e_pll, vecs[i].e_rstn,
                      vecs[i].e_rel, vecs[i].e_to);
        end

        // Lock glitch while STABILIZE count is 40: stabilization restarts.
        // Lock from release -> WAIT at edge7, STABILIZE at edge8; lock_s low seen at edge49.
        do_reset("glitch", 1'b1);
        tick(47);
        PLL_LOCKED = 1'b0;
        tick(1);
        PLL_LOCKED = 1'b1;
        tick(2);
        check_all("glitch_t50", 1'b0, 1'b0, 8'd0, 8'd0);
        tick(23);
        check1("glitch_t73_no_early_release", RST_N_OUT, 1'b0);
        tick(41);
        check1("glitch_t114_held", RST_N_OUT, 1'b0);
        tick(1);
        check_all("glitch_t115_release", 1'b0, 1'b1, 8'd0, 8'd0);

        // No lock for 2500 cycles: two timeouts (edges 1031, 2063) each re-pulsing PLL reset.
        do_reset("tmo", 1'b0);
        tick(1031);
        check_all("tmo_t1031", 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        check_all("tmo_t1032_repulse", 1'b1, 1'b0, 8'd0, 8'd1);
        tick(7);
        check1("tmo_t1039_pulse_end", PLL_RST, 1'b1);
        tick(1);
        check1("tmo_t1040_pulse_off", PLL_RST, 1'b0);
        tick(1024);
        check_all("tmo_t2064_second", 1'b1, 1'b0, 8'd0, 8'd2);
        tick(436);
        PLL_LOCKED = 1'b1;
        tick(66);
        check1("tmo_t2566_held", RST_N_OUT, 1'b0);
        tick(1);
        check_all("tmo_t2567_release", 1'b0, 1'b1, 8'd0, 8'd2);

        // Lock seen exactly when WAIT count is 1023 (edge1031): lock wins.
        do_reset("edge_lock", 1'b0);
        tick(1029);
        PLL_LOCKED = 1'b1;
        tick(3);
        check_all("edge_lock_t1032", 1'b0, 1'b0, 8'd0, 8'd0);
        tick(63);
        check1("edge_lock_t1095_held", RST_N_OUT, 1'b0);
        tick(1);
        check_all("edge_lock_t1096_release", 1'b0, 1'b1, 8'd0, 8'd0);

        // Lock seen one cycle too late: the timeout fires first.
        do_reset("late_lock", 1'b0);
        tick(1030);
        PLL_LOCKED = 1'b1;
        tick(2);
        check_all("late_lock_t1032", 1'b1, 1'b0, 8'd0, 8'd1);
        tick(72);
        check1("late_lock_t1104_held", RST_N_OUT, 1'b0);
        tick(1);
        check_all("late_lock_t1105_release", 1'b0, 1'b1, 8'd0, 8'd1);

        // 300 lock losses from RUN: counter saturates at 255.
        do_reset("sat", 1'b1);
        tick(80);
        check_all("sat_run", 1'b0, 1'b1, 8'd0, 8'd0);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            PLL_LOCKED = 1'b0;
            tick(3);
            exp_rel = (k >= 254) ? 8'd255 : 8'(k + 1);
            if (RELOCK_CNT !== exp_rel || RST_N_OUT !== 1'b0 || PLL_RST !== 1'b0) begin
                bad++;
            end
            PLL_LOCKED = 1'b1;
            tick(70);
        end
        check8("sat_iteration_errors", 8'(bad > 255 ? 255 : bad), 8'd0);
        check_all("sat_final", 1'b0, 1'b1, 8'd255, 8'd0);

        // Asynchronous reset mid-STABILIZE, checked between clock edges.
        PLL_LOCKED = 1'b0;
        tick(3);
        PLL_LOCKED = 1'b1;
        tick(10);
        check_all("mid_stab", 1'b0, 1'b0, 8'd255, 8'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check_all("async_rst", 1'b1, 1'b0, 8'd0, 8'd0);
        tick(2);
        RST_N = 1'b1;
        tick(7);
        check1("rerelease_t7", PLL_RST, 1'b1);
        tick(1);
        check1("rerelease_t8", PLL_RST, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ddr2_pll_reset_ctrl.md
DDR2_PLL_RESET_CTRL -- requirements
Module: ddr2_pll_reset_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 8: number of CLK cycles PLL_RST is held asserted per reset attempt (legal range 1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 1024: number of CLK cycles to wait for lock before re-resetting the PLL (legal range 2..65535).
REQ-003 Parameter STABLE_CYCLES, default 64: number of consecutive locked cycles required before releasing downstream reset (legal range 1..65535).
REQ-004 CLK  input  1  free-running reference clock, the same clock that feeds the PLL input; not a PLL output.
REQ-005 RST_N  input  1  asynchronous active-low reset; assertion is asynchronous.
REQ-006 PLL_LOCKED  input  1  PLL lock indication; asynchronous to CLK.
REQ-007 PLL_RST  output  1  active-high reset to the PLL; registered.
REQ-008 RST_N_OUT  output  1  active-low reset for logic clocked by the PLL outputs; registered.
REQ-009 RELOCK_CNT  output  8  count of lock losses seen in RUN; saturating.
REQ-010 TIMEOUT_CNT  output  8  count of lock timeouts in WAIT_LOCK; saturating.

Function
REQ-011 PLL_LOCKED shall pass through a 2-flop synchronizer; lock_s denotes the second flop; input-to-lock_s latency is 2 CLK edges.
REQ-012 The FSM shall have four states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN; it shall use a single 16-bit cycle counter, cleared on every state transition.
REQ-013 RESET_PLL: PLL_RST=1 and RST_N_OUT=0; the FSM shall leave for WAIT_LOCK on the edge where the counter equals PLL_RST_CYCLES-1, so that PLL_RST is high for exactly PLL_RST_CYCLES cycles.
REQ-014 WAIT_LOCK: PLL_RST=0 and RST_N_OUT=0; lock_s=1 shall go to STABILIZE; otherwise, when the counter equals LOCK_TIMEOUT-1, the FSM shall go to RESET_PLL and increment TIMEOUT_CNT.
REQ-015 If lock_s=1 in the same cycle the timeout is reached, the lock shall win: go to STABILIZE with no TIMEOUT_CNT increment.
REQ-016 STABILIZE: PLL_RST=0 and RST_N_OUT=0; lock_s=0 shall return to WAIT_LOCK with no counter increment and a fresh timeout; reaching counter STABLE_CYCLES-1 with lock_s=1 shall go to RUN.
REQ-017 RUN: PLL_RST=0 and RST_N_OUT=1; RST_N_OUT shall rise on the same edge the state becomes RUN.
REQ-018 RUN with lock_s=0 shall go to WAIT_LOCK, drive RST_N_OUT=0 on that same edge, and increment RELOCK_CNT.
REQ-019 RELOCK_CNT and TIMEOUT_CNT shall saturate at 255 and never wrap.
REQ-020 The cycle counter shall not increment in RUN; in other states it shall be unable to exceed its terminal value, so no wrap is possible.
REQ-021 Outputs shall be driven from flops only, with no combinational path from PLL_LOCKED to any output.

Reset
REQ-022 While RST_N=0: state=RESET_PLL, counter=0, sync flops=0, PLL_RST=1, RST_N_OUT=0, RELOCK_CNT=0, TIMEOUT_CNT=0, all asynchronously.
REQ-023 On RST_N deassertion, the PLL_RST_CYCLES count shall begin at the first CLK edge; RST_N asserted mid-operation in any state shall immediately force the REQ-022 values.

Verification
REQ-024 Defaults, PLL_LOCKED rises 20 cycles after reset release and stays high -> PLL_RST high for cycles 0..7; RST_N_OUT rises 64 cycles after lock_s=1; both counters remain 0.
REQ-025 PLL_LOCKED held 0 for 2500 cycles, then 1 -> PLL_RST re-pulses (8 cycles) after each 1024-cycle wait; TIMEOUT_CNT=2; then normal release.
REQ-026 In STABILIZE at count 40, drop PLL_LOCKED for 1 cycle -> RST_N_OUT stays 0; STABILIZE restarts; RST_N_OUT rises 64 cycles after lock_s returns; RELOCK_CNT=0.
REQ-027 In RUN, drop PLL_LOCKED -> RST_N_OUT falls 3 edges later (2 sync + 1 state); RELOCK_CNT=1; PLL_RST stays 0; release after re-lock plus 64 cycles.
REQ-028 Repeat REQ-027 300 times -> RELOCK_CNT=255, no wrap; assert RST_N mid-STABILIZE -> all outputs at REQ-022 values immediately, without waiting for a clock edge.
REQ-029 Lock rising exactly on the timeout cycle (lock_s=1 when counter=1023) -> STABILIZE entered, PLL_RST not pulsed, TIMEOUT_CNT unchanged.
